// File: rtl/m_reqack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_reqack_pkg
// Description : Shared types and defaults for the req/ack responder.
// Revision    : 1.0 - initial release
// ============================================================================
package m_reqack_pkg;

    localparam int NUM_LVL_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        EVAL  = 2'd2,
        ACK   = 2'd3
    } resp_state_e;

endpackage
`default_nettype wire

// File: rtl/m_lvl_ctr.sv
`default_nettype none
// ============================================================================
// Module      : m_lvl_ctr
// Description : Priority-level counter with clear, increment and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module m_lvl_ctr #(
    parameter int NUM_LVL = 4,
    parameter int LVL_W   = $clog2(NUM_LVL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [LVL_W-1:0] cnt,
    output logic             at_max
);

    localparam logic [LVL_W-1:0] c_LVL_MAX = LVL_W'(NUM_LVL - 1);

    logic [LVL_W-1:0] r_cnt;

    assign at_max = (r_cnt == c_LVL_MAX);
    assign cnt    = r_cnt;

    // Clear wins over increment; increment stalls once the top level is reached.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (inc && !at_max) begin
            r_cnt <= r_cnt + LVL_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/m_reqack_resp.sv
`default_nettype none
// ============================================================================
// Module      : m_reqack_resp
// Description : Escalating-priority request/acknowledge responder.
// Revision    : 1.0 - initial release
// ============================================================================
module m_reqack_resp
    import m_reqack_pkg::*;
#(
    parameter int NUM_LVL = NUM_LVL_DEF,
    parameter int LVL_W   = $clog2(NUM_LVL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready,
    input  logic               go,
    input  logic [NUM_LVL-1:0] req,
    input  logic [NUM_LVL-1:0] ack_en,
    output logic [NUM_LVL-1:0] ack,
    output logic               pass,
    output logic               fail,
    output logic               busy,
    output logic [LVL_W-1:0]   lvl
);

    resp_state_e        r_state;
    resp_state_e        w_state_nxt;
    logic [NUM_LVL-1:0] r_ack;
    logic [NUM_LVL-1:0] w_ack_nxt;
    logic               r_pass;
    logic               w_pass_nxt;
    logic               r_fail;
    logic               w_fail_nxt;
    logic               r_busy;
    logic               w_clr;
    logic               w_inc;
    logic               w_at_max;
    logic [LVL_W-1:0]   w_lvl;
    logic               w_hit;

    m_lvl_ctr #(
        .NUM_LVL (NUM_LVL),
        .LVL_W   (LVL_W)
    ) u_lvl_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_inc),
        .cnt    (w_lvl),
        .at_max (w_at_max)
    );

    // Only the level under evaluation is looked at.
    assign w_hit = req[w_lvl] & ack_en[w_lvl];

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b1;
        w_inc       = 1'b0;
        w_ack_nxt   = '0;
        w_pass_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ready) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (go)          w_state_nxt = EVAL;
                else if (!ready) w_state_nxt = IDLE;
            end
            EVAL: begin
                w_clr = 1'b0;
                if (w_hit) begin
                    w_state_nxt      = ACK;
                    w_ack_nxt[w_lvl] = 1'b1;
                    w_pass_nxt       = 1'b1;
                end else if (!w_at_max) begin
                    w_inc = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    w_fail_nxt  = 1'b1;
                end
            end
            ACK: begin
                // Level is held through ACK and cleared on the way out.
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= '0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_pass  <= w_pass_nxt;
            r_fail  <= w_fail_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign ack  = r_ack;
    assign pass = r_pass;
    assign fail = r_fail;
    assign busy = r_busy;
    assign lvl  = w_lvl;

endmodule
`default_nettype wire

// File: tb/tb_m_reqack_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_reqack_resp
// Description : Self-checking bench for m_reqack_resp (vectors + random model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_reqack_resp;

    localparam int NUM_LVL = 4;
    localparam int LVL_W   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ready = 1'b0;
    logic               go = 1'b0;
    logic [NUM_LVL-1:0] req = '0;
    logic [NUM_LVL-1:0] ack_en = '0;
    logic [NUM_LVL-1:0] ack;
    logic               pass;
    logic               fail;
    logic               busy;
    logic [LVL_W-1:0]   lvl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_reqack_resp #(.NUM_LVL(NUM_LVL), .LVL_W(LVL_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ready  (ready),
        .go     (go),
        .req    (req),
        .ack_en (ack_en),
        .ack    (ack),
        .pass   (pass),
        .fail   (fail),
        .busy   (busy),
        .lvl    (lvl)
    );

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack))
        else $error("FAIL a_onehot ack=%b", ack);
    a_ack_pass: assert property (@(posedge clk) disable iff (!rst_n) (|ack) |-> pass)
        else $error("FAIL a_ack_pass ack=%b pass=%b", ack, pass);
    a_ack_req: assert property (@(posedge clk) disable iff (!rst_n) ((ack & ~$past(req)) == '0))
        else $error("FAIL a_ack_req ack=%b", ack);
    a_excl: assert property (@(posedge clk) !(pass && fail))
        else $error("FAIL a_excl pass and fail both high");

    typedef struct {
        logic       rst_n, ready, go;
        logic [3:0] req, ack_en;
        logic [3:0] ack;
        logic       pass, fail, busy;
        logic [1:0] lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit rd, bit g, logic [3:0] rq, logic [3:0] en,
                               logic [3:0] a, bit p, bit f, bit b, int l);
        vec_t x;
        x.rst_n = r; x.ready = rd; x.go = g; x.req = rq; x.ack_en = en;
        x.ack = a; x.pass = p; x.fail = f; x.busy = b; x.lvl = 2'(l);
        return x;
    endfunction

    function automatic logic [8:0] outs();
        return {ack, pass, fail, busy, lvl};
    endfunction

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {ack,pass,fail,busy,lvl}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit rd, bit g, logic [3:0] rq, logic [3:0] en);
        rst_n = r; ready = rd; go = g; req = rq; ack_en = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: session bookkeeping in plain integers.
    bit m_armed, m_sess, m_fail;
    int m_lvl, m_ackd;

    task automatic model_reset();
        m_armed = 0; m_sess = 0; m_fail = 0; m_lvl = 0; m_ackd = -1;
    endtask

    function automatic logic [8:0] model_out();
        logic [3:0] a;
        logic [1:0] l;
        a = '0;
        l = '0;
        if (m_ackd >= 0) begin
            a[m_ackd] = 1'b1;
            l = 2'(m_ackd);
        end else if (m_sess) begin
            l = 2'(m_lvl);
        end
        return {a, (m_ackd >= 0), m_fail, (m_armed || m_sess || m_ackd >= 0), l};
    endfunction

    task automatic model_step(bit r, bit rd, bit g, logic [3:0] rq, logic [3:0] en);
        if (!r) begin
            model_reset();
        end else begin
            m_fail = 0;
            if (m_ackd >= 0) begin
                m_ackd = -1;
                m_lvl  = 0;
            end else if (m_sess) begin
                if (rq[m_lvl] && en[m_lvl]) begin
                    m_ackd = m_lvl;
                    m_sess = 0;
                end else if (m_lvl == NUM_LVL - 1) begin
                    m_sess = 0;
                    m_fail = 1;
                    m_lvl  = 0;
                end else begin
                    m_lvl = m_lvl + 1;
                end
            end else if (m_armed) begin
                if (g) begin
                    m_sess  = 1;
                    m_lvl   = 0;
                    m_armed = 0;
                end else begin
                    m_armed = rd;
                end
            end else begin
                m_armed = rd;
            end
        end
    endtask

    initial begin
        // Single request at level 0
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0001,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,1,1,4'b0000,4'b1111, 4'b0001,1,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        // Escalation to level 2
        vecs.push_back(v(1,1,0,4'b0100,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b0100,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0100,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0100,4'b1111, 4'b0000,0,0,1,1));
        vecs.push_back(v(1,0,0,4'b0100,4'b1111, 4'b0000,0,0,1,2));
        vecs.push_back(v(1,1,1,4'b0000,4'b1111, 4'b0100,1,0,1,2));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        // No request: full sweep then fail
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,1,1,4'b0000,4'b1111, 4'b0000,0,0,1,1));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,2));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,3));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,1,0,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        // All requests withheld by ack_en
        vecs.push_back(v(1,1,0,4'b1111,4'b0000, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b1111,4'b0000, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b1111,4'b0000, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b1111,4'b0000, 4'b0000,0,0,1,1));
        vecs.push_back(v(1,0,0,4'b1111,4'b0000, 4'b0000,0,0,1,2));
        vecs.push_back(v(1,0,0,4'b1111,4'b0000, 4'b0000,0,0,1,3));
        vecs.push_back(v(1,0,0,4'b1111,4'b0000, 4'b0000,0,1,0,0));
        // Only the top level enabled
        vecs.push_back(v(1,1,0,4'b1111,4'b1000, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b1111,4'b1000, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b1111,4'b1000, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b1111,4'b1000, 4'b0000,0,0,1,1));
        vecs.push_back(v(1,0,0,4'b1111,4'b1000, 4'b0000,0,0,1,2));
        vecs.push_back(v(1,0,0,4'b1111,4'b1000, 4'b0000,0,0,1,3));
        vecs.push_back(v(1,0,0,4'b0000,4'b1000, 4'b1000,1,0,1,3));
        vecs.push_back(v(1,0,0,4'b0000,4'b1000, 4'b0000,0,0,0,0));
        // Re-arm: ready, ready, go
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,1,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0001,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0001,1,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        // Armed then dropped back to idle
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        // go without preceding ready
        vecs.push_back(v(1,0,1,4'b1111,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b1111,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        // Reset at lvl=2, then ready on the first edge after release
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,1,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,1));
        vecs.push_back(v(0,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,2));
        vecs.push_back(v(1,1,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,1,0));
        vecs.push_back(v(1,0,0,4'b0000,4'b1111, 4'b0000,0,0,0,0));

        drive(0, 0, 0, '0, '0);
        tick();
        tick();
        check("reset", outs(), 9'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].ready, vecs[i].go, vecs[i].req, vecs[i].ack_en);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].ack, vecs[i].pass, vecs[i].fail, vecs[i].busy, vecs[i].lvl});
            tick();
        end

        // Reset landing on the ACK cycle must not leave a pass pulse behind
        drive(1, 1, 0, 4'b0000, 4'b1111); tick();
        drive(1, 0, 1, 4'b0000, 4'b1111); tick();
        drive(1, 0, 0, 4'b0010, 4'b1111); tick();
        drive(1, 0, 0, 4'b0010, 4'b1111); tick();
        check("ack_before_rst", outs(), {4'b0010, 1'b1, 1'b0, 1'b1, 2'd1});
        drive(0, 1, 1, 4'b0000, 4'b1111); tick();
        check("rst_in_ack", outs(), 9'b0);
        drive(1, 0, 0, 4'b0000, 4'b1111); tick();
        check("after_rst_ack", outs(), 9'b0);

        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bit         r, rd, g;
            logic [3:0] rq, en;
            r  = ($urandom_range(0, 99) != 0);
            rd = $urandom_range(0, 1) == 1;
            g  = $urandom_range(0, 1) == 1;
            rq = 4'($urandom_range(0, 15));
            en = (c < 1500) ? 4'($urandom_range(0, 15)) : 4'(1 << $urandom_range(0, 3));
            check($sformatf("rand%0d", c), outs(), model_out());
            drive(r, rd, g, rq, en);
            tick();
            model_step(r, rd, g, rq, en);
        end
        check("rand_final", outs(), model_out());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
